stream_tx_buffer: RTL and testbench

Buffers 32-bit stream words produced by the core interfaces and serialises them into bytes for the SPI byte interface's transmit register. Sits downstream of the core stream bus and upstream of the SPI tx byte path, in the system clock domain. This decouples bursty core output from the byte-at-a-time rate at which the MCU clocks data out.

---
 rtl/comms_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/stream_tx_buffer.sv | 137 +++++++++++++
 tb/tb_stream_tx_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/comms_pkg.sv
// Shared types and constants for the stream-to-byte transmit path.
// Byte-lane helpers assume 32-bit words, MSB-first transmission.
package comms_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] FILL_BYTE      = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] idx);
    case (idx)
      3'd0:    word_byte = word[31:24];
      3'd1:    word_byte = word[23:16];
      3'd2:    word_byte = word[15:8];
      3'd3:    word_byte = word[7:0];
      default: word_byte = FILL_BYTE;
    endcase
  endfunction

  function automatic logic [7:0] word_xor(input logic [31:0] word);
    word_xor = word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level counter; clear_i empties it synchronously.
// Pop-before-push on a full FIFO lets both happen in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && !clear_i && (level != '0);
  assign do_push = push_i && !clear_i && ((level != FULL_LVL) || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign full_o  = (level == FULL_LVL);
  assign empty_o = (level == '0);
  assign level_o = level;

endmodule

// File: rtl/stream_tx_buffer.sv
// Buffers 32-bit stream words and serialises them MSB-first into SPI tx bytes.
// Define STREAM_TX_BUFFER_CHECKSUM_EN to append an XOR checksum byte after each word.
//
// state | meaning
// IDLE  | no word held; filler byte presented, tx_valid_o low
// SHIFT | word held in word_q; byte idx_q presented, tx_valid_o high
module stream_tx_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stream_valid_i,
  input  logic [WIDTH-1:0]       stream_i,
  input  logic                   flush_i,
  input  logic                   byte_req_i,
  output logic [7:0]             tx_byte_o,
  output logic                   tx_valid_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   empty_o,
  output logic                   overflow_o
);

  import comms_pkg::*;

`ifdef STREAM_TX_BUFFER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD);
`else
  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);
`endif

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       tx_byte_d;
  logic             tx_valid_d;
  logic             overflow_d;
  logic             empty_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (fifo_push),
    .data_i  (stream_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_data;
          idx_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (byte_req_i) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 3'd1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            word_d   = fifo_data;
            idx_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d  = IDLE;
      idx_d    = '0;
      fifo_pop = 1'b0;
    end

    fifo_push  = stream_valid_i && !flush_i && (!fifo_full || fifo_pop);
    overflow_d = flush_i ? 1'b0
               : (overflow_o || (stream_valid_i && fifo_full && !fifo_pop));

    // Landing in IDLE implies the FIFO was empty this cycle, so only a push can refill it.
    empty_d = (state_d == IDLE) && !fifo_push;

    tx_valid_d = (state_d == SHIFT);
    tx_byte_d  = FILL_BYTE;
    if (state_d == SHIFT) begin
`ifdef STREAM_TX_BUFFER_CHECKSUM_EN
      tx_byte_d = (idx_d == LAST_IDX) ? word_xor(word_d) : word_byte(word_d, idx_d);
`else
      tx_byte_d = word_byte(word_d, idx_d);
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      tx_byte_o  <= FILL_BYTE;
      tx_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      empty_o    <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_byte_o  <= tx_byte_d;
      tx_valid_o <= tx_valid_d;
      overflow_o <= overflow_d;
      empty_o    <= empty_d;
    end
  end

endmodule

// File: tb/tb_stream_tx_buffer.sv
// Scoreboard bench for stream_tx_buffer: stimulus queues expected bytes, a negedge monitor
// compares every consumed byte. Honours STREAM_TX_BUFFER_CHECKSUM_EN for the byte stream model.
module tb_stream_tx_buffer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef STREAM_TX_BUFFER_CHECKSUM_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif

  logic          clk_i          = 1'b0;
  logic          rst_i          = 1'b1;
  logic          stream_valid_i = 1'b0;
  logic [31:0]   stream_i       = '0;
  logic          flush_i        = 1'b0;
  logic          byte_req_i     = 1'b0;
  logic [7:0]    tx_byte_o;
  logic          tx_valid_o;
  logic [LW-1:0] level_o;
  logic          empty_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  stream_tx_buffer #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stream_valid_i (stream_valid_i),
    .stream_i       (stream_i),
    .flush_i        (flush_i),
    .byte_req_i     (byte_req_i),
    .tx_byte_o      (tx_byte_o),
    .tx_valid_o     (tx_valid_o),
    .level_o        (level_o),
    .empty_o        (empty_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference byte stream: four bytes MSB first, optionally followed by their XOR.
  task automatic expect_word(input logic [31:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(w[31-8*i -: 8]);
      x ^= w[31-8*i -: 8];
    end
    if (BPW == 5) exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit accepted);
    stream_valid_i = 1'b1;
    stream_i       = w;
    if (accepted) expect_word(w);
    tick();
    stream_valid_i = 1'b0;
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    exp_q.delete();
    tick();
    flush_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    byte_req_i = 1'b1;
    while (exp_q.size() > 0 && n < 5000) begin
      tick();
      n++;
    end
    byte_req_i = 1'b0;
    check("drain_complete_bytes_left", exp_q.size(), 0);
  endtask

  // Monitor: a byte presented while byte_req_i is high is consumed at the next edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && !flush_i && byte_req_i) begin
        if (tx_valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", tx_byte_o);
          end else begin
            check("tx_byte", tx_byte_o, exp_q.pop_front());
          end
        end else begin
          check("filler_byte", tx_byte_o, 8'h00);
        end
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] w;
    int outstanding;

    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_tx_byte", tx_byte_o, 8'h00);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_level", level_o, 0);
    check("rst_empty", empty_o, 1'b1);
    check("rst_overflow", overflow_o, 1'b0);

    // Single word, two-cycle latency into the serialiser.
    push_word(32'hDEADBEEF, 1'b1);
    check("single_level_after_push", level_o, 1);
    check("single_empty_after_push", empty_o, 1'b0);
    tick();
    check("single_first_valid", tx_valid_o, 1'b1);
    check("single_first_byte", tx_byte_o, 8'hDE);
    check("single_level_after_pop", level_o, 0);
    byte_req_i = 1'b1;
    repeat (BPW) tick();
    byte_req_i = 1'b0;
    check("single_end_valid", tx_valid_o, 1'b0);
    check("single_end_byte", tx_byte_o, 8'h00);
    check("single_end_empty", empty_o, 1'b1);

    // Back-to-back words, no filler between them.
    stream_valid_i = 1'b1;
    stream_i = 32'h11223344;
    expect_word(32'h11223344);
    tick();
    check("b2b_level_1", level_o, 1);
    stream_i = 32'h55667788;
    expect_word(32'h55667788);
    tick();
    stream_valid_i = 1'b0;
    check("b2b_level_2", level_o, 1);
    check("b2b_first_byte", tx_byte_o, 8'h11);
    byte_req_i = 1'b1;
    for (int i = 0; i < 2 * BPW; i++) begin
      check("b2b_no_gap_valid", tx_valid_o, 1'b1);
      if (i == BPW) check("b2b_level_after_load", level_o, 0);
      tick();
    end
    byte_req_i = 1'b0;
    check("b2b_end_empty", empty_o, 1'b1);

    // Overflow: DEPTH+2 pushes, the last one dropped.
    flush_pulse();
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = $urandom;
      push_word(w, i < DEPTH + 1);
    end
    check("ovf_level_full", level_o, DEPTH);
    check("ovf_flag", overflow_o, 1'b1);
    check("ovf_ser_loaded", tx_valid_o, 1'b1);
    drain();
    check("ovf_sticky", overflow_o, 1'b1);
    check("ovf_end_empty", empty_o, 1'b1);

    // Full FIFO plus loaded serialiser; push coincides with the word-ending request.
    flush_pulse();
    check("flush_clears_overflow", overflow_o, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = $urandom;
      push_word(w, 1'b1);
    end
    check("fwp_level_full", level_o, DEPTH);
    check("fwp_no_overflow_yet", overflow_o, 1'b0);
    byte_req_i = 1'b1;
    repeat (BPW - 1) tick();
    w = $urandom;
    stream_valid_i = 1'b1;
    stream_i = w;
    expect_word(w);
    tick();
    stream_valid_i = 1'b0;
    byte_req_i = 1'b0;
    check("fwp_level_unchanged", level_o, DEPTH);
    check("fwp_overflow_clear", overflow_o, 1'b0);
    check("fwp_valid", tx_valid_o, 1'b1);
    drain();

    // Flush mid-word with a simultaneous push.
    flush_pulse();
    push_word(32'hA5A55A5A, 1'b1);
    tick();
    byte_req_i = 1'b1;
    repeat (2) tick();
    byte_req_i = 1'b0;
    flush_i = 1'b1;
    stream_valid_i = 1'b1;
    stream_i = 32'hCAFEF00D;
    exp_q.delete();
    tick();
    flush_i = 1'b0;
    stream_valid_i = 1'b0;
    check("flush_tx_byte", tx_byte_o, 8'h00);
    check("flush_tx_valid", tx_valid_o, 1'b0);
    check("flush_level", level_o, 0);
    check("flush_overflow", overflow_o, 1'b0);
    repeat (3) tick();
    check("flush_push_absent_level", level_o, 0);
    check("flush_push_absent_empty", empty_o, 1'b1);
    check("flush_push_absent_valid", tx_valid_o, 1'b0);

    // Asynchronous reset mid-word.
    push_word(32'h0BADC0DE, 1'b1);
    tick();
    byte_req_i = 1'b1;
    tick();
    byte_req_i = 1'b0;
    push_word(32'h12345678, 1'b1);
    #2;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("arst_tx_valid", tx_valid_o, 1'b0);
    check("arst_tx_byte", tx_byte_o, 8'h00);
    check("arst_level", level_o, 0);
    tick();
    rst_i = 1'b0;
    repeat (2) tick();
    check("arst_after_valid", tx_valid_o, 1'b0);
    check("arst_after_empty", empty_o, 1'b1);

    // Randomised traffic kept below capacity; every push is accepted.
    for (int c = 0; c < 800; c++) begin
      outstanding = (exp_q.size() + BPW - 1) / BPW;
      if ($urandom_range(0, 2) == 0 && outstanding < DEPTH) begin
        w = $urandom;
        stream_valid_i = 1'b1;
        stream_i = w;
        expect_word(w);
      end else begin
        stream_valid_i = 1'b0;
      end
      byte_req_i = ($urandom_range(0, 1) == 1);
      tick();
    end
    stream_valid_i = 1'b0;
    drain();
    tick();
    check("rand_end_empty", empty_o, 1'b1);
    check("rand_end_level", level_o, 0);
    check("rand_end_overflow", overflow_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
